// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared constants and helpers for the button conditioner
//
// Purpose : default parameter values for btn_debounce and a small helper
//           used to size the optional auto-repeat counter.
// Ports   : none (package).
package btn_pkg;

  localparam int BTN_WIDTH_DEFAULT         = 11;          // 5 bottom + 6 key
  localparam int BTN_DEBOUNCE_DEFAULT      = 2_000_000;   // 20 ms at 100 MHz
  localparam int BTN_REPEAT_DELAY_DEFAULT  = 50_000_000;  // 500 ms at 100 MHz
  localparam int BTN_REPEAT_PERIOD_DEFAULT = 10_000_000;  // 100 ms at 100 MHz

  function automatic int btn_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: synchroniser, bounce filter, edge pulses
//
// Purpose : conditions one raw asynchronous button into a debounced level
//           plus registered one-cycle press/release pulses.
// Macro   : BTN_REPEAT_EN adds an auto-repeat press generator while held.
// Ports   :
//   clk_i      - system clock
//   rst_ni     - asynchronous active-low reset
//   raw_i      - raw button, active-high, asynchronous
//   level_o    - debounced level
//   press_o    - one-cycle pulse on accepted press (and each repeat)
//   release_o  - one-cycle pulse on accepted release
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
  parameter int REPEAT_DELAY    = BTN_REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD   = BTN_REPEAT_PERIOD_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             accept;
  logic             rep_fire;

  // accept: the synchronised input has differed from stable for the full window
  always_comb begin
    accept    = (sync2_q != stable_q) && (cnt_q == CNT_LAST);
    stable_d  = stable_q;
    cnt_d     = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;              // any glitch back to stable restarts the window
    end else if (accept) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // Pulses are registered so they line up with the first cycle of the new level
    press_d   = (accept & sync2_q) | rep_fire;
    release_d = accept & ~sync2_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int REP_W = $clog2(btn_max(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_first_q, rep_first_d;  // 1 until the first repeat has fired
  logic [REP_W-1:0] rep_target;

  // rep_cnt counts edges since the last press pulse; it reloads to 0 on
  // every pulse so no saturation logic is needed.
  always_comb begin
    rep_target  = rep_first_q ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1);
    rep_fire    = 1'b0;
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    if (accept) begin
      // new press arms the initial delay; release clears (and blocks a pulse)
      rep_cnt_d   = '0;
      rep_first_d = sync2_q;
    end else if (stable_q) begin
      if (rep_cnt_q == rep_target) begin
        rep_fire    = 1'b1;
        rep_cnt_d   = '0;
        rep_first_d = 1'b0;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end else begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  logic unused_repeat_params;
  assign unused_repeat_params = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rep_fire = 1'b0;
`endif

  assign level_o   = stable_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - multi-channel button synchroniser and debouncer
//
// Purpose : WIDTH independent button channels feeding the game controller
//           with clean levels and one-cycle press/release events.
// Macro   : BTN_REPEAT_EN enables per-channel auto-repeat press pulses.
// Ports   :
//   sys_clk     - system clock
//   rst         - asynchronous active-low reset
//   btn_raw     - raw buttons, active-high, asynchronous
//   btn_level   - debounced level per channel
//   btn_press   - one-cycle press pulse per channel
//   btn_release - one-cycle release pulse per channel
module btn_debounce
  import btn_pkg::*;
#(
  parameter int WIDTH           = BTN_WIDTH_DEFAULT,
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
  parameter int REPEAT_DELAY    = BTN_REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD   = BTN_REPEAT_PERIOD_DEFAULT
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk_i     (sys_clk),
      .rst_ni    (rst),
      .raw_i     (btn_raw[i]),
      .level_o   (btn_level[i]),
      .press_o   (btn_press[i]),
      .release_o (btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - directed self-checking bench for btn_debounce
module tb_btn_debounce;

  localparam int W = 11;

`ifdef BTN_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic         sys_clk = 1'b0;
  logic         rst;
  logic [W-1:0] btn_raw;
  logic [W-1:0] btn_level;
  logic [W-1:0] btn_press;
  logic [W-1:0] btn_release;

  int checks   = 0;
  int failures = 0;

  btn_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance n rising edges, land 1 time unit after the last one
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  initial begin
    logic         seen;
    logic [W-1:0] exp_p;
    logic [W-1:0] exp_r;

    rst     = 1'b0;
    btn_raw = '0;
    tick(2);
    check("reset_level",   32'(btn_level),   32'h0);
    check("reset_press",   32'(btn_press),   32'h0);
    check("reset_release", 32'(btn_release), 32'h0);
    rst = 1'b1;
    tick(2);

    // 1. clean press on channel 0
    btn_raw[0] = 1'b1;
    tick(5);
    check("t1_level_e5", 32'(btn_level), 32'h0);
    check("t1_press_e5", 32'(btn_press), 32'h0);
    tick(1);
    check("t1_level_e6", 32'(btn_level), 32'h001);
    check("t1_press_e6", 32'(btn_press), 32'h001);
    check("t1_rel_e6",   32'(btn_release), 32'h0);
    tick(1);
    check("t1_press_e7", 32'(btn_press), 32'h0);

    // 2. bounce on channel 3: high 3, low 1, high 2, low
    seen = 1'b0;
    btn_raw[3] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (btn_level[3] || btn_press[3] || btn_release[3]) seen = 1'b1;
      if (k == 2) btn_raw[3] = 1'b0;
      if (k == 3) btn_raw[3] = 1'b1;
      if (k == 5) btn_raw[3] = 1'b0;
    end
    check("t2_bounce_quiet", 32'(seen), 32'h0);
    btn_raw[3] = 1'b1;
    tick(5);
    check("t2_level_e5", 32'(btn_level), 32'h001);
    tick(1);
    check("t2_level_e6", 32'(btn_level), 32'h009);
    check("t2_press_e6", 32'(btn_press), 32'h008);

    // 3. release channel 0
    tick(1);
    btn_raw[0] = 1'b0;
    tick(5);
    check("t3_level_e5", 32'(btn_level), 32'h009);
    tick(1);
    check("t3_level_e6", 32'(btn_level),   32'h008);
    check("t3_rel_e6",   32'(btn_release), 32'h001);
    check("t3_press_e6", 32'(btn_press),   32'h0);
    tick(1);
    check("t3_rel_e7",   32'(btn_release), 32'h0);
    btn_raw[3] = 1'b0;
    tick(8);
    check("t3_all_low", 32'(btn_level), 32'h0);

    // 4. all channels together
    btn_raw = '1;
    tick(5);
    check("t4_press_e5", 32'(btn_press), 32'h0);
    tick(1);
    check("t4_press_e6", 32'(btn_press), 32'h7FF);
    check("t4_level_e6", 32'(btn_level), 32'h7FF);
    tick(1);
    check("t4_press_e7", 32'(btn_press), 32'h0);
    btn_raw = '0;
    tick(5);
    check("t4_rel_e5", 32'(btn_release), 32'h0);
    tick(1);
    check("t4_rel_e6",   32'(btn_release), 32'h7FF);
    check("t4_press_r6", 32'(btn_press),   32'h0);
    tick(4);

    // 5. reset while channel 1 is mid-count (cnt=2), channel 0 held
    btn_raw[0] = 1'b1;
    tick(6);
    check("t5_pre_level", 32'(btn_level), 32'h001);
    btn_raw[1] = 1'b1;
    tick(4);
    rst = 1'b0;
    #1;
    check("t5_rst_level", 32'(btn_level), 32'h0);
    check("t5_rst_press", 32'(btn_press), 32'h0);
    tick(2);
    rst = 1'b1;
    tick(5);
    check("t5_level_e5", 32'(btn_level), 32'h0);
    tick(1);
    check("t5_press_e6", 32'(btn_press), 32'h003);
    check("t5_level_e6", 32'(btn_level), 32'h003);
    btn_raw = '0;
    tick(8);

    // 6. hold channel 5; repeats at P+10, P+13, P+16 (then P+19 before release lands)
    btn_raw[5] = 1'b1;
    tick(6);
    check("t6_press_P", 32'(btn_press), 32'h020);
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (k == 16) btn_raw[5] = 1'b0;
      exp_p = '0;
      exp_r = '0;
      if (REP && (k == 10 || k == 13 || k == 16 || k == 19)) exp_p = 11'h020;
      if (k == 22) exp_r = 11'h020;
      check($sformatf("t6_press_P+%0d", k), 32'(btn_press), 32'(exp_p));
      check($sformatf("t6_rel_P+%0d", k),   32'(btn_release), 32'(exp_r));
      if (k == 21) check("t6_level_P+21", 32'(btn_level), 32'h020);
      if (k == 22) check("t6_level_P+22", 32'(btn_level), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Multi-channel button conditioner sitting directly upstream of the game controller. It synchronises the raw board push-buttons and keys into the system clock domain and filters contact bounce. For each channel it produces a debounced level plus single-cycle press and release pulses. The game controller consumes the pulses as clean "button pressed" events in place of raw pins.

## Interface
- `WIDTH`, default 11: number of button channels (5 `bottom` + 6 `key`).
- `DEBOUNCE_CYCLES`, default 2_000_000: consecutive stable samples required before accepting a change (20 ms at 100 MHz); must be ≥ 2.
- `REPEAT_DELAY`, default 50_000_000: cycles from press pulse to first auto-repeat pulse (repeat build only).
- `REPEAT_PERIOD`, default 10_000_000: cycles between subsequent auto-repeat pulses (repeat build only).

Ports:
- `sys_clk`: input, 1 bit. Single system clock.
- `rst`: input, 1 bit. Asynchronous, active-low reset.
- `btn_raw`: input, WIDTH bits. Asynchronous raw buttons, active-high (1 = pressed).
- `btn_level`: output, WIDTH bits. Debounced state per channel.
- `btn_press`: output, WIDTH bits. One-cycle pulse per accepted press (and per repeat, if enabled).
- `btn_release`: output, WIDTH bits. One-cycle pulse per accepted release.

## Operation
- Each channel is fully independent; there is no cross-channel interaction.
- Synchroniser: two flops per channel, `sync1 <= btn_raw`, `sync2 <= sync1`. Reset value 0.
- Filter: counter `cnt` of width `$clog2(DEBOUNCE_CYCLES+1)` plus register `stable`.
  - If `sync2 == stable`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= sync2`, `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
  - Any mismatch shorter than DEBOUNCE_CYCLES samples is discarded. A glitch back to `stable` restarts the count from 0.
- `btn_level = stable`.
- `btn_press` and `btn_release` are registered. Each is 1 in exactly the first cycle `btn_level` shows the new value (1 and 0 respectively). They are never asserted together on one channel.
- No wrap-around: `cnt` never exceeds DEBOUNCE_CYCLES-1.
- Reset (async, any time, including mid-count): all sync flops, `cnt`, `stable` and the repeat state go to 0. `btn_level`, `btn_press` and `btn_release` read 0 immediately.
  - A button held through reset is seen as a fresh press after release of reset, following the normal latency.

## Timing
- Raw edge held steady → `btn_level` change: DEBOUNCE_CYCLES + 2 rising edges (2 sync, DEBOUNCE_CYCLES filter).
- `btn_press`/`btn_release` pulse: high for exactly 1 cycle, aligned with the first cycle of the new `btn_level`.
- Minimum accepted press-to-release spacing: DEBOUNCE_CYCLES cycles of stable input.
- Throughput: independent of other channels. All WIDTH channels may fire pulses in the same cycle.

## Configuration
- Macro `BTN_REPEAT_EN`.
- **Defined:** per-channel repeat counter. While `stable` = 1, a further one-cycle `btn_press` pulse occurs REPEAT_DELAY cycles after the initial press pulse, then every REPEAT_PERIOD cycles.
  - Release, or reset, clears the repeat counter immediately.
  - No repeat pulse in the release cycle.
  - The repeat counter saturates logic-free by reloading to 0 on each pulse.
- **Undefined:** no repeat logic is generated. Exactly one `btn_press` per accepted press. REPEAT_* parameters are ignored.

## Structure
- Shared package `btn_pkg`: default constants `BTN_DEBOUNCE_DEFAULT`, `BTN_REPEAT_DELAY_DEFAULT`, `BTN_REPEAT_PERIOD_DEFAULT`, and `BTN_WIDTH_DEFAULT = 11`.
- Sub-module `btn_debounce_ch`: one channel (sync, filter, edge pulses, optional repeat). The top instantiates it WIDTH times in a generate loop.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
1. **Clean press:** raise `btn_raw[0]` and hold → `btn_level[0]` = 1 and a single `btn_press[0]` pulse exactly 6 edges later. Other channels stay 0.
2. **Bounce rejection:** toggle `btn_raw[3]` high 3 cycles / low 1 / high 2 / low → `btn_level[3]` stays 0, no pulses. Then hold high → press after 6 edges from last rise.
3. **Release:** from a held state, drop `btn_raw[0]` → `btn_release[0]` for 1 cycle 6 edges later, `btn_level[0]` = 0, no `btn_press`.
4. **Simultaneous:** drive all 11 channels high in the same cycle → all 11 `btn_press` bits high in the same single cycle.
5. **Reset mid-operation:** assert `rst` = 0 while `cnt` = 2 on a rising channel → outputs 0 immediately. Release `rst` with the button still held → press 6 edges after release.
6. **Auto-repeat (`BTN_REPEAT_EN`):** hold channel 5 → pulses at press cycle P, P+10, P+13, P+16. Release → pulses stop and `btn_release` fires. Without the macro → only the pulse at P.
